// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor: diff = a - b - borrow_in, DIGIT bits per clock, LSB slice first,
// with a start/busy/done handshake and registered borrow/overflow results.
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow
);

    localparam int NSLICE = WIDTH / DIGIT;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST_SLICE = CW'(NSLICE - 1);

    generate
        if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
            $error("serial_subtractor: WIDTH must be >= 1 and a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:0]  r_diff;
    logic              r_bw;
    logic              r_borrow;
    logic              r_overflow;
    logic              r_busy;
    logic              r_done;
    logic [CW-1:0]     r_cnt;

    logic              w_accept;
    logic              w_last;
    logic              w_busy_nxt;
    logic              w_done_nxt;
    int                w_base;
    logic [DIGIT-1:0]  w_a_sl;
    logic [DIGIT-1:0]  w_b_sl;
    logic [DIGIT:0]    w_sub;
    logic [DIGIT-1:0]  w_d;
    logic              w_bo;
    logic              w_ovf;

    assign w_accept = start & ((r_state == S_IDLE) | (r_state == S_DONE));
    assign w_last   = (r_cnt == LAST_SLICE);

    // The extra top bit of the (DIGIT+1)-bit difference is the slice borrow-out.
    assign w_base = int'(r_cnt) * DIGIT;
    assign w_a_sl = r_a[w_base +: DIGIT];
    assign w_b_sl = r_b[w_base +: DIGIT];
    assign w_sub  = {1'b0, w_a_sl} - {1'b0, w_b_sl} - {{DIGIT{1'b0}}, r_bw};
    assign w_d    = w_sub[DIGIT-1:0];
    assign w_bo   = w_sub[DIGIT];

    // The last slice carries the result MSB, so overflow can be formed on that edge.
    assign w_ovf  = (r_a[WIDTH-1] ^ r_b[WIDTH-1]) & (w_d[DIGIT-1] ^ r_a[WIDTH-1]);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            S_DONE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state, so busy/done can be registered
    always_comb begin
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
        case (w_state_nxt)
            S_RUN: begin
                w_busy_nxt = 1'b1;
            end
            S_DONE: begin
                w_done_nxt = 1'b1;
            end
            default: begin
                w_busy_nxt = 1'b0;
                w_done_nxt = 1'b0;
            end
        endcase
    end

    // Handshake output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
        end
    end

    // Operand capture and slice-by-slice datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a        <= {WIDTH{1'b0}};
            r_b        <= {WIDTH{1'b0}};
            r_diff     <= {WIDTH{1'b0}};
            r_bw       <= 1'b0;
            r_borrow   <= 1'b0;
            r_overflow <= 1'b0;
            r_cnt      <= {CW{1'b0}};
        end else if (w_accept) begin
            r_a   <= a;
            r_b   <= b;
            r_bw  <= borrow_in;
            r_cnt <= {CW{1'b0}};
        end else if (r_state == S_RUN) begin
            r_diff[w_base +: DIGIT] <= w_d;
            r_bw                    <= w_bo;
            if (w_last) begin
                r_cnt      <= {CW{1'b0}};
                r_borrow   <= w_bo;
                r_overflow <= w_ovf;
            end else begin
                r_cnt      <= r_cnt + CW'(1);
            end
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign diff     = r_diff;
    assign borrow   = r_borrow;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: four configurations (8/1, 8/4, 8/2, 1/1)
// checked every cycle against an arithmetic reference model, plus literal expectations.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] start_s = 4'h0;
    logic [3:0] bin_s   = 4'h0;
    logic [7:0] a_s [4];
    logic [7:0] b_s [4];
    logic [3:0] busy_s, done_s, bor_s, ovf_s;
    logic [7:0] diff_s [4];

    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    task automatic check(string nm, int g, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s [inst %0d]: got %0h expected %0h at %0t", nm, g, got, exp, $time);
        end
    endtask

    function automatic int ns_of(int idx);
        case (idx)
            0:       return 8;
            1:       return 2;
            2:       return 4;
            default: return 1;
        endcase
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int W  = (g == 3) ? 1 : 8;
        localparam int D  = (g == 0 || g == 3) ? 1 : ((g == 1) ? 4 : 2);
        localparam int NS = W / D;

        logic [W-1:0] d_w;
        logic bsy_w, dn_w, bo_w, ov_w;

        serial_subtractor #(.WIDTH(W), .DIGIT(D)) u_dut (
            .clk(clk), .rst(rst), .start(start_s[g]),
            .a(a_s[g][W-1:0]), .b(b_s[g][W-1:0]), .borrow_in(bin_s[g]),
            .busy(bsy_w), .done(dn_w), .diff(d_w), .borrow(bo_w), .overflow(ov_w)
        );

        assign busy_s[g] = bsy_w;
        assign done_s[g] = dn_w;
        assign bor_s[g]  = bo_w;
        assign ovf_s[g]  = ov_w;
        assign diff_s[g] = 8'(d_w);

        // Reference model: edge-count timing plus plain integer arithmetic
        int ecount = 0;
        int e0 = 0;
        bit act = 1'b0, val = 1'b0, seen = 1'b0, xb = 1'b0, xd = 1'b0;
        bit eb = 1'b0, eo = 1'b0, pb = 1'b0, po = 1'b0;
        logic [W-1:0] ed = '0, pd = '0;

        always @(posedge clk) begin
            int full, sa, sb, sf;
            ecount++;
            seen = 1'b1;
            if (rst) begin
                act = 1'b0; val = 1'b1; ed = '0; eb = 1'b0; eo = 1'b0;
            end else if (start_s[g] && (!act || ecount >= e0 + NS + 1)) begin
                act  = 1'b1;
                e0   = ecount;
                val  = 1'b0;
                full = int'(a_s[g][W-1:0]) - int'(b_s[g][W-1:0]) - int'(bin_s[g]);
                pd   = W'(full);
                pb   = (full < 0);
                sa   = int'(a_s[g][W-1:0]) - (a_s[g][W-1] ? (1 << W) : 0);
                sb   = int'(b_s[g][W-1:0]) - (b_s[g][W-1] ? (1 << W) : 0);
                sf   = sa - sb - int'(bin_s[g]);
                po   = (sf > (1 << (W-1)) - 1) || (sf < -(1 << (W-1)));
            end
            if (act && ecount == e0 + NS) begin
                val = 1'b1; ed = pd; eb = pb; eo = po;
            end
            xb = act && (ecount >= e0) && (ecount <= e0 + NS - 1);
            xd = act && (ecount == e0 + NS);
        end

        always @(negedge clk) begin
            if (seen) begin
                check("busy", g, 32'(bsy_w), 32'(xb));
                check("done", g, 32'(dn_w), 32'(xd));
                if (val) begin
                    check("diff", g, 32'(d_w), 32'(ed));
                    check("borrow", g, 32'(bo_w), 32'(eb));
                    check("overflow", g, 32'(ov_w), 32'(eo));
                end
            end
        end
    end

    task automatic do_op(int idx, logic [7:0] av, logic [7:0] bv, logic bi,
                         logic [7:0] xdf, logic xbo, logic xov, bit poke);
        int cnt;
        bit hit;
        int ns;
        ns = ns_of(idx);
        @(negedge clk);
        a_s[idx] = av; b_s[idx] = bv; bin_s[idx] = bi; start_s[idx] = 1'b1;
        @(negedge clk);
        start_s[idx] = 1'b0;
        a_s[idx] = ~av; b_s[idx] = ~bv; bin_s[idx] = ~bi;
        cnt = 1;
        hit = 1'b0;
        while (!hit && cnt <= ns + 4) begin
            if (done_s[idx]) begin
                hit = 1'b1;
            end else begin
                start_s[idx] = (poke && cnt == 3);
                @(negedge clk);
                cnt++;
            end
        end
        start_s[idx] = 1'b0;
        check("latency", idx, hit ? cnt : -1, ns + 1);
        check("diff_lit", idx, 32'(diff_s[idx]), 32'(xdf));
        check("borrow_lit", idx, 32'(bor_s[idx]), 32'(xbo));
        check("overflow_lit", idx, 32'(ovf_s[idx]), 32'(xov));
        @(negedge clk);
    endtask

    initial begin
        int last, gaps;
        for (int i = 0; i < 4; i++) begin
            a_s[i] = 8'h00;
            b_s[i] = 8'h00;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_busy", 0, 32'(busy_s), 32'h0);
        check("rst_done", 0, 32'(done_s), 32'h0);
        check("rst_diff", 0, 32'(diff_s[0]), 32'h0);
        check("rst_flags", 0, 32'({bor_s, ovf_s}), 32'h0);

        do_op(0, 8'h05, 8'h03, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
        do_op(1, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0);
        do_op(2, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0);
        do_op(2, 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0);
        do_op(0, 8'h30, 8'h10, 1'b0, 8'h20, 1'b0, 1'b0, 1'b1);
        do_op(0, 8'h55, 8'h55, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);

        // Reset three slices into an operation
        @(negedge clk);
        a_s[0] = 8'h57; b_s[0] = 8'h11; bin_s[0] = 1'b0; start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", 0, 32'(busy_s[0]), 32'h0);
        check("midrst_done", 0, 32'(done_s[0]), 32'h0);
        check("midrst_diff", 0, 32'(diff_s[0]), 32'h0);
        check("midrst_flags", 0, 32'({bor_s[0], ovf_s[0]}), 32'h0);
        do_op(0, 8'h57, 8'h11, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0);

        // start held high with operands changing every cycle
        last = -1;
        gaps = 0;
        start_s[0] = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            a_s[0] = 8'($urandom); b_s[0] = 8'($urandom); bin_s[0] = 1'($urandom);
            if (done_s[0]) begin
                if (last >= 0 && gaps < 3) begin
                    check("b2b_gap", 0, c - last, 9);
                    gaps++;
                end
                last = c;
            end
        end
        start_s[0] = 1'b0;
        check("b2b_seen", 0, gaps, 3);
        repeat (12) @(negedge clk);

        // Random traffic on all configurations, with occasional resets
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < 4; i++) begin
                start_s[i] = ($urandom_range(0, 2) == 0);
                a_s[i]     = 8'($urandom);
                b_s[i]     = 8'($urandom);
                bin_s[i]   = 1'($urandom);
            end
        end
        rst = 1'b0;
        start_s = 4'h0;
        repeat (12) @(negedge clk);

        // Exhaustive one-bit truth table from the boolean equations
        for (int v = 0; v < 8; v++) begin
            logic ai, bi, ci, dd, bo, ov;
            ai = v[2]; bi = v[1]; ci = v[0];
            dd = ai ^ bi ^ ci;
            bo = (!ai & bi) | (!ai & ci) | (bi & ci);
            ov = (ai != bi) && (dd != ai);
            do_op(3, 8'(ai), 8'(bi), ci, 8'(dd), bo, ov, 1'b0);
        end

        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
